// File: rtl/scale_price_engine_if.sv
// Bus between the weighing front end / label logic and the price engine.
// master: whoever drives weight, tare, price-table and start controls.
// slave:  the price engine itself.
interface scale_price_engine_if #(
  parameter int W_WEIGHT   = 14,
  parameter int W_PRICE    = 14,
  parameter int W_TOTAL    = 20,
  parameter int N_PRODUCTS = 8
);
  localparam int AW = $clog2(N_PRODUCTS);

  logic [W_WEIGHT-1:0] weight_grams;
  logic                tare_capture;
  logic                tare_clear;
  logic                price_wr_en;
  logic [AW-1:0]       price_wr_addr;
  logic [W_PRICE-1:0]  price_wr_data;
  logic [AW-1:0]       prod_sel;
  logic                start;
  logic                busy;
  logic                done;
  logic [W_WEIGHT-1:0] net_grams;
  logic [W_TOTAL-1:0]  total_cents;
  logic                under_tare;
  logic                overflow;
  logic [W_WEIGHT-1:0] tare_grams;

  modport master (
    output weight_grams, tare_capture, tare_clear, price_wr_en,
           price_wr_addr, price_wr_data, prod_sel, start,
    input  busy, done, net_grams, total_cents, under_tare, overflow,
           tare_grams
  );

  modport slave (
    input  weight_grams, tare_capture, tare_clear, price_wr_en,
           price_wr_addr, price_wr_data, prod_sel, start,
    output busy, done, net_grams, total_cents, under_tare, overflow,
           tare_grams
  );
endinterface

// File: rtl/scale_price_engine.sv
// Price engine: total = round(net_g * price_cents_per_kg / 1000) using a
// bit-serial shift-add multiplier and a restoring divide-by-1000.
//
// state | meaning
// IDLE  | waiting for start; snapshot net weight, under-tare flag and price
// MUL   | one multiplier (net) bit per cycle, LSB first
// BIAS  | add 500 so the truncating divide rounds half up
// DIV   | one quotient bit per cycle, MSB first, divisor 1000
// DONE  | saturate quotient; results and done pulse appear on the next edge
module scale_price_engine #(
  parameter int W_WEIGHT   = 14,
  parameter int W_PRICE    = 14,
  parameter int W_TOTAL    = 20,
  parameter int N_PRODUCTS = 8
) (
  input logic                  clk,
  input logic                  reset,
  scale_price_engine_if.slave  bus
);
  localparam int W_PROD = W_WEIGHT + W_PRICE;
  localparam int W_ACC  = W_PROD + 1;
  localparam int CNT_W  = $clog2(W_ACC);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_BIAS = 3'd2;
  localparam logic [2:0] S_DIV  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [10:0]      DIVISOR = 11'd1000;
  localparam logic [W_ACC-1:0] ROUND   = W_ACC'(500);

  logic [2:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [W_PRICE-1:0]  price_q [N_PRODUCTS];
  logic [W_WEIGHT-1:0] tare_q;
  logic [W_WEIGHT-1:0] net_s_q;
  logic                under_s_q;
  logic [W_PROD-1:0]   mcand_q;
  logic [W_WEIGHT-1:0] mplier_q;
  logic [W_ACC-1:0]    acc_q;
  logic [9:0]          rem_q;
  logic                busy_q, done_q, under_o_q, ovf_q;
  logic [W_WEIGHT-1:0] net_o_q;
  logic [W_TOTAL-1:0]  total_q;

  logic                under_calc;
  logic [W_WEIGHT-1:0] net_calc;
  logic [W_ACC-1:0]    addend;
  logic [10:0]         rem_sh;
  logic                q_bit;
  logic [9:0]          rem_d;
  logic                sat;
  logic [W_TOTAL-1:0]  total_nx;

  // Net weight clamps at zero when the tare exceeds the gross reading.
  always_comb begin
    under_calc = bus.weight_grams < tare_q;
    net_calc   = under_calc ? '0 : bus.weight_grams - tare_q;
    addend     = mplier_q[0] ? {1'b0, mcand_q} : '0;
    rem_sh     = {rem_q, acc_q[W_ACC-1]};
    q_bit      = rem_sh >= DIVISOR;
    rem_d      = q_bit ? 10'(rem_sh - DIVISOR) : rem_sh[9:0];
    sat        = (acc_q >> W_TOTAL) != '0;
    total_nx   = sat ? '1 : W_TOTAL'(acc_q);
  end

  // Next-state sequencing; cnt_q counts down the remaining serial steps.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_MUL;
      S_MUL:   if (cnt_q == '0) state_d = S_BIAS;
      S_BIAS:  state_d = S_DIV;
      S_DIV:   if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Tare register; clear takes priority over capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 tare_q <= '0;
    else if (bus.tare_clear)   tare_q <= '0;
    else if (bus.tare_capture) tare_q <= bus.weight_grams;
  end

  // Price table; a same-cycle write is not seen by the snapshot read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_PRODUCTS; i++) price_q[i] <= '0;
    end else if (bus.price_wr_en) begin
      price_q[bus.price_wr_addr] <= bus.price_wr_data;
    end
  end

  // Serial datapath and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      net_s_q   <= '0;
      under_s_q <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      net_o_q   <= '0;
      total_q   <= '0;
      under_o_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.start) begin
          net_s_q   <= net_calc;
          under_s_q <= under_calc;
          mplier_q  <= net_calc;
          mcand_q   <= W_PROD'(price_q[bus.prod_sel]);
          acc_q     <= '0;
          cnt_q     <= CNT_W'(W_WEIGHT - 1);
          busy_q    <= 1'b1;
        end
        S_MUL: begin
          acc_q    <= acc_q + addend;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        end
        S_BIAS: begin
          acc_q <= acc_q + ROUND;
          rem_q <= '0;
          cnt_q <= CNT_W'(W_PROD);
        end
        S_DIV: begin
          rem_q <= rem_d;
          acc_q <= {acc_q[W_ACC-2:0], q_bit};
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        end
        S_DONE: begin
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          net_o_q   <= net_s_q;
          total_q   <= total_nx;
          under_o_q <= under_s_q;
          ovf_q     <= sat;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.net_grams   = net_o_q;
  assign bus.total_cents = total_q;
  assign bus.under_tare  = under_o_q;
  assign bus.overflow    = ovf_q;
  assign bus.tare_grams  = tare_q;
endmodule

// File: tb/tb_scale_price_engine.sv
// Scoreboard bench: two engines (default width and a narrow 10-bit total)
// share one stimulus stream; expected results are queued at start acceptance
// and checked by an independent monitor on each done pulse.
module tb_scale_price_engine;
  localparam int WW = 14, WP = 14, WT = 20, WTB = 10, NP = 8;
  localparam int AW = $clog2(NP);
  localparam int LAT = WW + (WW + WP) + 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [WW-1:0] weight;
  logic          tare_capture, tare_clear, price_wr_en, start;
  logic [AW-1:0] price_wr_addr, prod_sel;
  logic [WP-1:0] price_wr_data;

  scale_price_engine_if #(.W_WEIGHT(WW), .W_PRICE(WP), .W_TOTAL(WT),  .N_PRODUCTS(NP)) ifa ();
  scale_price_engine_if #(.W_WEIGHT(WW), .W_PRICE(WP), .W_TOTAL(WTB), .N_PRODUCTS(NP)) ifb ();

  assign ifa.weight_grams = weight;        assign ifb.weight_grams = weight;
  assign ifa.tare_capture = tare_capture;  assign ifb.tare_capture = tare_capture;
  assign ifa.tare_clear = tare_clear;      assign ifb.tare_clear = tare_clear;
  assign ifa.price_wr_en = price_wr_en;    assign ifb.price_wr_en = price_wr_en;
  assign ifa.price_wr_addr = price_wr_addr; assign ifb.price_wr_addr = price_wr_addr;
  assign ifa.price_wr_data = price_wr_data; assign ifb.price_wr_data = price_wr_data;
  assign ifa.prod_sel = prod_sel;          assign ifb.prod_sel = prod_sel;
  assign ifa.start = start;                assign ifb.start = start;

  scale_price_engine #(.W_WEIGHT(WW), .W_PRICE(WP), .W_TOTAL(WT), .N_PRODUCTS(NP))
    u_dut_a (.clk(clk), .reset(rst), .bus(ifa));
  scale_price_engine #(.W_WEIGHT(WW), .W_PRICE(WP), .W_TOTAL(WTB), .N_PRODUCTS(NP))
    u_dut_b (.clk(clk), .reset(rst), .bus(ifb));

  typedef struct {
    longint net;
    longint tot_a;
    longint tot_b;
    bit     under;
    bit     ovf_a;
    bit     ovf_b;
    int     acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0, n_done = 0, n_push = 0;
  int   cyc = 0;
  int   tare_sh;
  int   price_sh[NP];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(int g, int t, int p);
    exp_t   e;
    longint q, max_a, max_b;
    max_a   = (longint'(1) << WT) - 1;
    max_b   = (longint'(1) << WTB) - 1;
    e.under = g < t;
    e.net   = e.under ? 0 : g - t;
    q       = (e.net * p + 500) / 1000;
    e.ovf_a = q > max_a;
    e.ovf_b = q > max_b;
    e.tot_a = e.ovf_a ? max_a : q;
    e.tot_b = e.ovf_b ? max_b : q;
    e.acc   = 0;
    return e;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst && (ifa.done || ifb.done)) begin
      chk("done_a_b_aligned", longint'(ifb.done), longint'(ifa.done));
      if (ifa.done) begin
        n_done++;
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1, expected no pending computation (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency",      longint'(cyc - e.acc),   longint'(LAT));
          chk("net_grams",    longint'(ifa.net_grams), e.net);
          chk("total_cents",  longint'(ifa.total_cents), e.tot_a);
          chk("under_tare",   longint'(ifa.under_tare), longint'(e.under));
          chk("overflow",     longint'(ifa.overflow),  longint'(e.ovf_a));
          chk("total_narrow", longint'(ifb.total_cents), e.tot_b);
          chk("ovf_narrow",   longint'(ifb.overflow),  longint'(e.ovf_b));
          chk("busy_at_done", longint'(ifa.busy),      0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (ifa.busy && k < 200) begin tick(); k++; end
    if (ifa.busy) begin
      n_chk++; n_fail++;
      $display("FAIL busy_timeout: got busy=1, expected 0 within 200 cycles");
    end
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb.size() != 0 && k < 300) begin tick(); k++; end
    if (sb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
    end
  endtask

  task automatic start_comp(input int w, input int sel);
    exp_t e;
    wait_ready();
    weight   = WW'(w);
    prod_sel = AW'(sel);
    start    = 1'b1;
    e        = model(w, tare_sh, price_sh[sel]);
    tick();
    e.acc = cyc;
    sb.push_back(e);
    n_push++;
    start = 1'b0;
  endtask

  task automatic write_price(input int a, input int d);
    price_wr_en   = 1'b1;
    price_wr_addr = AW'(a);
    price_wr_data = WP'(d);
    tick();
    price_wr_en = 1'b0;
    price_sh[a] = d;
  endtask

  task automatic capture_tare(input int w);
    weight       = WW'(w);
    tare_capture = 1'b1;
    tick();
    tare_capture = 1'b0;
    tare_sh      = w;
    chk("tare_grams_capture", longint'(ifa.tare_grams), tare_sh);
  endtask

  task automatic clear_tare();
    tare_clear = 1'b1;
    tare_capture = 1'b1;
    tick();
    tare_clear = 1'b0;
    tare_capture = 1'b0;
    tare_sh    = 0;
    chk("tare_grams_clear", longint'(ifa.tare_grams), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_net"},   longint'(ifa.net_grams),   0);
    chk({tag, "_total"}, longint'(ifa.total_cents), 0);
    chk({tag, "_under"}, longint'(ifa.under_tare),  0);
    chk({tag, "_ovf"},   longint'(ifa.overflow),    0);
    chk({tag, "_done"},  longint'(ifa.done),        0);
    chk({tag, "_busy"},  longint'(ifa.busy),        0);
    chk({tag, "_tare"},  longint'(ifa.tare_grams),  0);
    chk({tag, "_total_narrow"}, longint'(ifb.total_cents), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected end within 200000 ns");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    weight = '0; tare_capture = 0; tare_clear = 0; price_wr_en = 0;
    price_wr_addr = '0; price_wr_data = '0; prod_sel = '0; start = 0;
    tare_sh = 0;
    for (int i = 0; i < NP; i++) price_sh[i] = 0;
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    // Defaults: 1500 g at 460 c/kg -> 690.
    write_price(0, 460);
    start_comp(1500, 0);
    wait_drain();

    // Tare 200 g -> net 1300, 598.
    capture_tare(200);
    start_comp(1500, 0);
    wait_drain();

    // Rounding at 1 g; second price written while the first runs.
    clear_tare();
    write_price(1, 500);
    start_comp(1, 1);
    write_price(1, 499);
    start_comp(1, 1);
    wait_drain();

    // Under-tare.
    capture_tare(200);
    start_comp(100, 0);
    wait_drain();

    // Narrow engine saturates at 1023.
    clear_tare();
    write_price(2, 1000);
    start_comp(1500, 2);
    wait_drain();

    // Start pulses while busy are ignored; mid-run write to selected entry.
    start_comp(3000, 0);
    for (int i = 0; i < 6; i++) begin
      repeat (3) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      if (i == 2) write_price(0, 9999);
    end
    wait_drain();

    // Write to the selected entry in the accepting cycle: old value used.
    wait_ready();
    weight = WW'(800); prod_sel = '0; start = 1'b1;
    price_wr_en = 1'b1; price_wr_addr = '0; price_wr_data = WP'(1234);
    e = model(800, tare_sh, price_sh[0]);
    tick();
    e.acc = cyc; sb.push_back(e); n_push++;
    start = 1'b0; price_wr_en = 1'b0; price_sh[0] = 1234;
    start_comp(800, 0);
    wait_drain();

    // Reset mid-computation: no done, outputs cleared, clean restart.
    capture_tare(50);
    write_price(3, 777);
    start_comp(2500, 3);
    repeat (19) tick();
    #2 rst = 1'b1;
    #1 chk_zero("midreset");
    n_push -= sb.size();
    sb.delete();
    tare_sh = 0;
    for (int i = 0; i < NP; i++) price_sh[i] = 0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (60) tick();
    write_price(3, 777);
    start_comp(2500, 3);
    wait_drain();

    // Randomized mix of tare, table writes and computations.
    for (int it = 0; it < 30; it++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op == 0)      capture_tare(int'($urandom_range(0, 3000)));
      else if (op == 1) clear_tare();
      else if (op <= 4) write_price(int'($urandom_range(0, NP - 1)), int'($urandom_range(0, 16383)));
      start_comp(int'($urandom_range(0, 16383)), int'($urandom_range(0, NP - 1)));
    end
    wait_drain();
    repeat (5) tick();

    chk("done_count", longint'(n_done), longint'(n_push));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/scale_price_engine.md
Name: scale_price_engine

Overview:
- Sequential price-computation engine for the weighing-scale datapath.
- Holds a programmable price-per-kg table (N_PRODUCTS entries) and a tare register.
- On a start handshake, computes net weight = gross − tare, then total price = round(net_g × price_cents_per_kg / 1000).
- Uses a bit-serial shift-add multiplier and a restoring divider, so area stays small. Drives the display/price-label logic downstream.

Parameters:
W_WEIGHT, 14, width of gross/tare/net weight in grams
W_PRICE, 14, width of price-per-kg in centimos
W_TOTAL, 20, width of total price output in centimos
N_PRODUCTS, 8, number of price table entries (power of 2, >=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
weight_grams  in  W_WEIGHT  live gross weight from load cell front end
tare_capture  in  1  pulse: tare_reg <= weight_grams
tare_clear  in  1  pulse: tare_reg <= 0 (wins over tare_capture)
price_wr_en  in  1  write strobe for price table
price_wr_addr  in  log2(N_PRODUCTS)  table write address
price_wr_data  in  W_PRICE  centimos per kg
prod_sel  in  log2(N_PRODUCTS)  product used by next computation
start  in  1  request computation (accepted only when busy=0)
busy  out  1  computation in progress
done  out  1  one-cycle pulse, results valid
net_grams  out  W_WEIGHT  net weight of last computation
total_cents  out  W_TOTAL  rounded price of last computation
under_tare  out  1  gross < tare in last computation
overflow  out  1  total saturated in last computation
tare_grams  out  W_WEIGHT  current tare register

Behaviour:
- Reset (async): all outputs 0, tare_reg 0, all price table entries 0, FSM to IDLE. Reset mid-computation aborts it with no done pulse.
- Tare and price-table writes are accepted in any state. A computation uses the snapshot taken at start acceptance, so later writes do not affect it. A write to the entry being snapshotted in the same cycle: the old value is used.
- FSM states:
  - IDLE: start=1 → snapshot; busy=1 next cycle.
    - net = gross − tare; if gross < tare then net = 0 and under_tare flag = 1.
    - Latch price[prod_sel].
    - Go to MUL.
  - MUL: W_WEIGHT cycles, one multiplier bit per cycle, LSB first. Product width W_PROD = W_WEIGHT + W_PRICE.
  - BIAS: 1 cycle, product += 500 (round half up). Carry is kept in a W_PROD+1 bit accumulator.
  - DIV: W_PROD+1 cycles of restoring division by 1000.
  - DONE: 1 cycle. done=1, busy=0, result registers loaded. Next state IDLE.
- Latency: done is high exactly LAT = W_WEIGHT + W_PROD + 3 cycles after the edge that accepts start. The default is 45.
- start while busy=1 is ignored (no queue). start held high in IDLE after DONE begins a new computation immediately.
- Saturation: if quotient > 2^W_TOTAL − 1, then total_cents = all ones and overflow = 1.
- Result outputs (net_grams, total_cents, under_tare, overflow) hold their values until the next DONE.
- tare_grams reflects tare_reg continuously.
- net = 0 or price = 0 → total 0 (500/1000 rounds to 0).

Test Plan:
1. Defaults: price[0]=460, tare 0, weight 1500, prod_sel 0, start → done at cycle 45; net_grams=1500, total_cents=690, flags 0.
2. Tare: weight 200, tare_capture; then weight 1500, start → net_grams=1300, total_cents=598, tare_grams=200.
3. Rounding: weight 1 (tare cleared), price 500 → total 1; price 499 → total 0.
4. Under-tare: tare 200, weight 100 → net_grams 0, total 0, under_tare=1.
5. Overflow with W_TOTAL=10 override: weight 1500, price 1000 → total_cents=1023, overflow=1.
6. Robustness:
   - start pulses during busy are ignored; exactly one done.
   - price_wr to the selected entry mid-computation does not change the result.
   - reset asserted at cycle 20 → all outputs 0, no done; a new start afterwards gives the correct result.
